// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and FSM encoding for the multiword add sequencer.
// Word width default and state type live here so the datapath can be swapped.
package multiword_add_seq_pkg;

  localparam int W_COE = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request, result and adder-datapath signals of the multiword add sequencer.
// master = upstream/adder side, slave = the sequencer itself.
interface multiword_add_seq_if #(
  parameter int WIDTH  = multiword_add_seq_pkg::W_COE,
  parameter int NWORDS = 4
);

  localparam int OW = NWORDS * WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_a;
  logic [OW-1:0] in_b;
  logic          in_cin;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic          out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output out_valid, out_sum, out_cout,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_cin,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  out_valid, out_sum, out_cout,
    output out_ready
  );

endinterface

// File: rtl/multiword_add_seq.sv
// Feeds a wide add one word per cycle (LSW first) to an external adder,
// chains the carry through a register and collects the wide result.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH  = W_COE,
  parameter int NWORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus,
  output logic                busy
);

  localparam int OW = NWORDS * WIDTH;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic          carry;
  logic [OW-1:0] op_a;
  logic [OW-1:0] op_b;
  logic [OW-1:0] res;
  logic          cout_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake/datapath drive.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    busy          = 1'b1;
    unique case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        bus.add_a   = op_a[idx*WIDTH +: WIDTH];
        bus.add_b   = op_b[idx*WIDTH +: WIDTH];
        bus.add_cin = carry;
        if (idx == LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        busy     = 1'b0;
      end
    endcase
  end

  // Operand latch, word index, carry chain and result collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.in_valid) begin
        op_a  <= bus.in_a;
        op_b  <= bus.in_b;
        carry <= bus.in_cin;
        idx   <= '0;
      end
      if (state == S_RUN) begin
        res[idx*WIDTH +: WIDTH] <= bus.add_sum;
        carry                   <= bus.add_cout;
        if (idx == LAST) cout_q <= bus.add_cout;
        else             idx    <= idx + 1'b1;
      end
    end
  end

  assign bus.out_sum  = res;
  assign bus.out_cout = cout_q;

endmodule
